// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, ALU operations, FSM states and the control word shared by the control unit
package cpu_pkg;
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;
  localparam logic [4:0] ALU_ADD = 5'd3;
  localparam logic [4:0] ALU_SUB = 5'd4;
  localparam logic [4:0] ALU_AND = 5'd9;
  localparam logic [4:0] ALU_OR  = 5'd10;
  localparam logic [4:0] ALU_INC = 5'd12;
  // T0..T7 must stay consecutive: the sequencer advances by incrementing
  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;
  typedef enum logic [3:0] {
    C_RR, C_IMM, C_LD, C_LDI, C_ST, C_BR, C_IN, C_OUT, C_NOP, C_HALT
  } iclass_t;
  typedef struct packed {
    logic       PCout;
    logic       Zlowout;
    logic       MDRout;
    logic       BAout;
    logic       Cout;
    logic       InPortOut;
    logic       PCin;
    logic       MARin;
    logic       MDRin;
    logic       IRin;
    logic       Yin;
    logic       Zin;
    logic       Rin;
    logic       CONin;
    logic       OutportIn;
    logic       Gra;
    logic       Grb;
    logic       Grc;
    logic       Rout;
    logic       Read;
    logic       Write;
    logic [4:0] OpCode;
  } ctrl_t;
endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: instruction/status inputs and datapath strobes of the control unit
// CU_MEM_WAIT_EN adds the Mem_ready handshake input.
interface control_unit_if;
  logic [31:0] IR;
  logic        CON_FF;
  logic        Stop;
  logic        Run;
`ifdef CU_MEM_WAIT_EN
  logic        Mem_ready;
`endif
  logic PCout, Zlowout, MDRout, BAout, Cout, InPortOut;
  logic PCin, MARin, MDRin, IRin, Yin, Zin, Rin, CONin, OutportIn;
  logic Gra, Grb, Grc, Rout;
  logic Read, Write;
  logic [4:0] OpCode;
  modport master (
`ifdef CU_MEM_WAIT_EN
    input  Mem_ready,
`endif
    input  IR, CON_FF, Stop,
    output Run, PCout, Zlowout, MDRout, BAout, Cout, InPortOut,
    output PCin, MARin, MDRin, IRin, Yin, Zin, Rin, CONin, OutportIn,
    output Gra, Grb, Grc, Rout, Read, Write, OpCode
  );
  modport slave (
`ifdef CU_MEM_WAIT_EN
    output Mem_ready,
`endif
    output IR, CON_FF, Stop,
    input  Run, PCout, Zlowout, MDRout, BAout, Cout, InPortOut,
    input  PCin, MARin, MDRin, IRin, Yin, Zin, Rin, CONin, OutportIn,
    input  Gra, Grb, Grc, Rout, Read, Write, OpCode
  );
endinterface

// File: rtl/cu_decoder.sv
// cu_decoder: maps an opcode to its instruction class and the ALU op of its arithmetic step
module cu_decoder
  import cpu_pkg::*;
(
  input  logic [4:0] opcode,
  output iclass_t    cls,
  output logic [4:0] alu_op
);
  // undefined opcodes fall through as nop
  always_comb begin
    cls    = C_NOP;
    alu_op = ALU_ADD;
    case (opcode)
      OP_LD:   cls = C_LD;
      OP_LDI:  cls = C_LDI;
      OP_ST:   cls = C_ST;
      OP_ADD:  cls = C_RR;
      OP_SUB:  begin cls = C_RR;  alu_op = ALU_SUB; end
      OP_AND:  begin cls = C_RR;  alu_op = ALU_AND; end
      OP_OR:   begin cls = C_RR;  alu_op = ALU_OR;  end
      OP_ADDI: cls = C_IMM;
      OP_ANDI: begin cls = C_IMM; alu_op = ALU_AND; end
      OP_ORI:  begin cls = C_IMM; alu_op = ALU_OR;  end
      OP_BR:   cls = C_BR;
      OP_IN:   cls = C_IN;
      OP_OUT:  cls = C_OUT;
      OP_NOP:  cls = C_NOP;
      OP_HALT: cls = C_HALT;
      default: cls = C_NOP;
    endcase
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: Moore sequencer issuing fetch/execute control strobes for the CPU datapath
// CU_MEM_WAIT_EN: hold T1 and ld T6 until Mem_ready=1.
module control_unit
  import cpu_pkg::*;
(
  input logic            clk,
  input logic            clr,
  control_unit_if.master cu
);
  state_t     state, state_nx;
  iclass_t    cls;
  logic [4:0] alu_op;
  logic       last, stall;
  ctrl_t      c;
  cu_decoder u_dec (.opcode(cu.IR[31:27]), .cls(cls), .alu_op(alu_op));
`ifdef CU_MEM_WAIT_EN
  assign stall = !cu.Mem_ready && (state == S_T1 || (state == S_T6 && cls == C_LD));
`else
  assign stall = 1'b0;
`endif
  // last step of each instruction: the only point where Stop is honoured
  assign last = state == S_T7 ||
                (state == S_T3 && cls inside {C_IN, C_OUT, C_NOP}) ||
                (state == S_T5 && cls inside {C_RR, C_IMM, C_LDI}) ||
                (state == S_T6 && cls == C_BR);
  always_ff @(posedge clk or negedge clr)
    if (!clr) state <= S_RESET;
    else      state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == S_RESET) state_nx = S_T0;
    else if (state == S_HALT || (state == S_T3 && cls == C_HALT)) state_nx = S_HALT;
    else if (last) state_nx = cu.Stop ? S_HALT : S_T0;
    else if (!stall) state_nx = state_t'(state + 4'd1);
  end
  always_comb begin
    c = '0;
    case (state)
      S_T0: begin c.PCout = 1'b1; c.MARin = 1'b1; c.Zin = 1'b1; c.OpCode = ALU_INC; end
      S_T1: begin c.Zlowout = 1'b1; c.PCin = 1'b1; c.Read = 1'b1; c.MDRin = 1'b1; end
      S_T2: begin c.MDRout = 1'b1; c.IRin = 1'b1; end
      S_T3:
        case (cls)
          C_RR, C_IMM:       begin c.Grb = 1'b1; c.Rout = 1'b1; c.Yin = 1'b1; end
          C_LD, C_LDI, C_ST: begin c.Grb = 1'b1; c.BAout = 1'b1; c.Yin = 1'b1; end
          C_BR:              begin c.Gra = 1'b1; c.Rout = 1'b1; c.CONin = 1'b1; end
          C_IN:              begin c.Gra = 1'b1; c.Rin = 1'b1; c.InPortOut = 1'b1; end
          C_OUT:             begin c.Gra = 1'b1; c.Rout = 1'b1; c.OutportIn = 1'b1; end
          default: ;
        endcase
      S_T4:
        case (cls)
          C_RR:                     begin c.Grc = 1'b1; c.Rout = 1'b1; c.Zin = 1'b1; c.OpCode = alu_op; end
          C_IMM, C_LD, C_LDI, C_ST: begin c.Cout = 1'b1; c.Zin = 1'b1; c.OpCode = alu_op; end
          C_BR:                     begin c.PCout = 1'b1; c.Yin = 1'b1; end
          default: ;
        endcase
      S_T5:
        case (cls)
          C_RR, C_IMM, C_LDI: begin c.Zlowout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
          C_LD, C_ST:         begin c.Zlowout = 1'b1; c.MARin = 1'b1; end
          C_BR:               begin c.Cout = 1'b1; c.Zin = 1'b1; c.OpCode = ALU_ADD; end
          default: ;
        endcase
      S_T6:
        case (cls)
          C_LD:    begin c.Read = 1'b1; c.MDRin = 1'b1; end
          C_ST:    begin c.Gra = 1'b1; c.Rout = 1'b1; c.MDRin = 1'b1; end
          C_BR:    begin c.Zlowout = 1'b1; c.PCin = cu.CON_FF; end
          default: ;
        endcase
      S_T7:
        case (cls)
          C_LD:    begin c.MDRout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
          C_ST:    c.Write = 1'b1;
          default: ;
        endcase
      default: ;
    endcase
  end
  assign cu.Run = state != S_HALT;
  assign {cu.PCout, cu.Zlowout, cu.MDRout, cu.BAout, cu.Cout, cu.InPortOut,
          cu.PCin, cu.MARin, cu.MDRin, cu.IRin, cu.Yin, cu.Zin, cu.Rin, cu.CONin, cu.OutportIn,
          cu.Gra, cu.Grb, cu.Grc, cu.Rout, cu.Read, cu.Write, cu.OpCode} = c;
endmodule
